// File: rtl/arrow_lanes.sv
// arrow_lanes: several arrows fall down the screen, one per fixed x column.
// Each lane runs its own WAIT/FALL/HIT/MISS state machine. Motion and respawn
// delays advance only on the frame tick. A shared LFSR supplies per-spawn speed
// and respawn delay. Button rising edges inside the hit window score a hit.
// Score and combo are shared across all lanes.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   animate    one-clk frame tick
//   x, y       current pixel column/row from the VGA scanner
//   btn        per-lane button levels (already synchronised)
//   arrow_pix  per-lane "pixel lies on this lane's glyph" (combinational)
//   any_pix    OR of arrow_pix
//   hit_pulse  per-lane one-clk hit pulse (registered)
//   miss_pulse per-lane one-clk miss pulse (registered)
//   yc_bus     lane i centre y at bits [10i+9:10i]
//   score      total hits, saturating at 16'hFFFF
//   combo      hits since the last miss, saturating at 255
module arrow_lanes #(
    parameter int         LANES      = 4,
    parameter int         LANE_X0    = 160,
    parameter int         LANE_PITCH = 100,
    parameter int         Y_START    = 50,
    parameter int         Y_MISS     = 460,
    parameter int         HIT_LO     = 400,
    parameter int         HIT_HI     = 440,
    parameter int         BASE_SPEED = 3,
    parameter int         RANDOM     = 1,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  animate,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic [LANES-1:0]      btn,
    output logic [LANES-1:0]      arrow_pix,
    output logic                  any_pix,
    output logic [LANES-1:0]      hit_pulse,
    output logic [LANES-1:0]      miss_pulse,
    output logic [10*LANES-1:0]   yc_bus,
    output logic [15:0]           score,
    output logic [7:0]            combo
);

    typedef enum logic [1:0] {S_WAIT, S_FALL, S_HIT, S_MISS} lane_state_t;

    localparam logic [9:0]  Y_START_C = 10'(Y_START);
    localparam logic [9:0]  Y_MISS_C  = 10'(Y_MISS);
    localparam logic [10:0] Y_MISS_W  = 11'(Y_MISS);
    localparam logic [9:0]  HIT_LO_C  = 10'(HIT_LO);
    localparam logic [9:0]  HIT_HI_C  = 10'(HIT_HI);
    localparam logic [9:0]  BASE_C    = 10'(BASE_SPEED);

    lane_state_t     state_q [LANES];
    lane_state_t     state_d [LANES];
    logic [4:0]      cnt_q   [LANES];
    logic [4:0]      cnt_d   [LANES];
    logic [9:0]      yc_q    [LANES];
    logic [9:0]      yc_d    [LANES];
    logic [9:0]      spd_q   [LANES];
    logic [9:0]      spd_d   [LANES];

    logic [7:0]       lfsr_q, lfsr_d;
    logic [LANES-1:0] btn_q;
    logic [LANES-1:0] rise;
    logic [LANES-1:0] hit_q, miss_q;
    logic [15:0]      score_q, score_d;
    logic [7:0]       combo_q, combo_d;
    logic [9:0]       new_spd;
    logic [4:0]       new_dly;

    function automatic logic [3:0] popcount(input logic [LANES-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < LANES; k++) begin
            n = n + {3'b000, v[k]};
        end
        return n;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3)
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    assign new_spd = (RANDOM != 0) ? BASE_C + {8'd0, lfsr_q[1:0]} : BASE_C;
    assign new_dly = (RANDOM != 0) ? {1'b0, lfsr_q[3:0]} + 5'd1 : 5'd1;

    assign rise = btn & ~btn_q;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            logic [10:0] ny;
            ny         = {1'b0, yc_q[i]} + {1'b0, spd_q[i]};
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            yc_d[i]    = yc_q[i];
            spd_d[i]   = spd_q[i];
            case (state_q[i])
                S_WAIT: begin
                    if (animate) begin
                        if (cnt_q[i] == 5'd1) begin
                            yc_d[i]    = Y_START_C;
                            spd_d[i]   = new_spd;
                            state_d[i] = S_FALL;
                        end else begin
                            cnt_d[i] = cnt_q[i] - 5'd1;
                        end
                    end
                end
                S_FALL: begin
                    // A qualifying press wins over motion in the same clock.
                    if (rise[i] && (yc_q[i] >= HIT_LO_C) && (yc_q[i] <= HIT_HI_C)) begin
                        state_d[i] = S_HIT;
                    end else if (animate) begin
                        if (ny >= Y_MISS_W) begin
                            yc_d[i]    = Y_MISS_C;
                            state_d[i] = S_MISS;
                        end else begin
                            yc_d[i] = ny[9:0];
                        end
                    end
                end
                default: begin
                    state_d[i] = S_WAIT;
                    cnt_d[i]   = new_dly;
                end
            endcase
        end
    end

    always_comb begin
        score_d = sat_add16(score_q, popcount(hit_q));
        // A miss anywhere breaks the combo even if other lanes hit this clock.
        combo_d = (|miss_q) ? 8'd0 : sat_add8(combo_q, popcount(hit_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q  <= LFSR_SEED;
            btn_q   <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            score_q <= 16'd0;
            combo_q <= 8'd0;
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= S_WAIT;
                cnt_q[i]   <= 5'(2 * i + 1);
                yc_q[i]    <= Y_START_C;
                spd_q[i]   <= BASE_C;
            end
        end else begin
            lfsr_q  <= lfsr_d;
            btn_q   <= btn;
            score_q <= score_d;
            combo_q <= combo_d;
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                yc_q[i]    <= yc_d[i];
                spd_q[i]   <= spd_d[i];
                hit_q[i]   <= (state_d[i] == S_HIT);
                miss_q[i]  <= (state_d[i] == S_MISS);
            end
        end
    end

    // Glyph rendering in 12-bit signed space so xc-k / yc-12 never wrap.
    logic signed [11:0] x_s, y_s;
    assign x_s = signed'({2'b00, x});
    assign y_s = signed'({2'b00, y});

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam logic signed [11:0] XC = 12'(LANE_X0 + g * LANE_PITCH);
        logic signed [11:0] yc_s;
        logic signed [11:0] kk;
        logic               stem, head;

        assign yc_s = signed'({2'b00, yc_q[g]});
        assign stem = (x_s >= XC - 12'sd6) && (x_s < XC + 12'sd6) &&
                      (y_s >= yc_s - 12'sd12) && (y_s < yc_s + 12'sd2);

        always_comb begin
            head = 1'b0;
            kk   = 12'sd0;
            for (int k = 0; k < 10; k++) begin
                kk = 12'(k);
                if ((x_s >= XC - 12'sd1 - kk) && (x_s < XC + 12'sd1 + kk) &&
                    (y_s >= yc_s + 12'sd9 - kk) && (y_s < yc_s + 12'sd12 - kk)) begin
                    head = 1'b1;
                end
            end
        end

        assign arrow_pix[g]        = (state_q[g] == S_FALL) && (stem || head);
        assign yc_bus[10*g +: 10]  = yc_q[g];
    end

    assign any_pix    = |arrow_pix;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign score      = score_q;
    assign combo      = combo_q;

endmodule

// File: tb/tb_arrow_lanes.sv
// Bench for arrow_lanes: behavioural model compared every clock, plus
// hand-computed expectations for reset, glyph probes, hit, held button,
// miss, async reset and combo saturation.
module tb_arrow_lanes;
    localparam int LANES = 4, LANE_X0 = 160, LANE_PITCH = 100, Y_START = 50;
    localparam int Y_MISS = 460, HIT_LO = 400, HIT_HI = 440, BASE_SPEED = 3, RANDOM = 1;
    localparam int M_WAIT = 0, M_FALL = 1, M_HIT = 2, M_MISS = 3;

    logic clk = 1'b0, rst = 1'b0, animate = 1'b0;
    logic [9:0] x = '0, y = '0;
    logic [LANES-1:0] btn = '0;
    logic [LANES-1:0] arrow_pix, hit_pulse, miss_pulse;
    logic any_pix;
    logic [10*LANES-1:0] yc_bus;
    logic [15:0] score;
    logic [7:0] combo;

    always #5 clk = ~clk;

    arrow_lanes #(.LANES(LANES), .LANE_X0(LANE_X0), .LANE_PITCH(LANE_PITCH),
                  .Y_START(Y_START), .Y_MISS(Y_MISS), .HIT_LO(HIT_LO), .HIT_HI(HIT_HI),
                  .BASE_SPEED(BASE_SPEED), .RANDOM(RANDOM), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .rst(rst), .animate(animate), .x(x), .y(y), .btn(btn),
        .arrow_pix(arrow_pix), .any_pix(any_pix), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .yc_bus(yc_bus), .score(score), .combo(combo));

    int checks = 0, failures = 0;
    bit cmp_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures < 50) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_st[LANES], m_cnt[LANES], m_yc[LANES], m_spd[LANES];
    bit m_btnq[LANES];
    int m_score, m_combo;
    logic [7:0] m_lfsr;

    function automatic bit m_pix(int i, int px, int py);
        int dx, dy;
        if (m_st[i] != M_FALL) return 0;
        dx = px - (LANE_X0 + i * LANE_PITCH);
        dy = py - m_yc[i];
        if (dx >= -6 && dx < 6 && dy >= -12 && dy < 2) return 1;
        for (int k = 0; k < 10; k++)
            if (dx >= -1 - k && dx < 1 + k && dy >= 9 - k && dy < 12 - k) return 1;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr = 8'hA5; m_score = 0; m_combo = 0;
            for (int i = 0; i < LANES; i++) begin
                m_st[i] = M_WAIT; m_cnt[i] = 2 * i + 1; m_yc[i] = Y_START;
                m_spd[i] = BASE_SPEED; m_btnq[i] = 0;
            end
        end else begin
            int nh, nm;
            nh = 0; nm = 0;
            for (int i = 0; i < LANES; i++) begin
                if (m_st[i] == M_HIT) nh++;
                if (m_st[i] == M_MISS) nm++;
            end
            m_score = (m_score + nh > 65535) ? 65535 : m_score + nh;
            m_combo = (nm > 0) ? 0 : ((m_combo + nh > 255) ? 255 : m_combo + nh);
            for (int i = 0; i < LANES; i++) begin
                bit r;
                r = btn[i] && !m_btnq[i];
                case (m_st[i])
                    M_WAIT: if (animate) begin
                        if (m_cnt[i] == 1) begin
                            m_yc[i] = Y_START;
                            m_spd[i] = BASE_SPEED + (RANDOM ? int'(m_lfsr) % 4 : 0);
                            m_st[i] = M_FALL;
                        end else m_cnt[i]--;
                    end
                    M_FALL: begin
                        if (r && m_yc[i] >= HIT_LO && m_yc[i] <= HIT_HI) m_st[i] = M_HIT;
                        else if (animate) begin
                            if (m_yc[i] + m_spd[i] >= Y_MISS) begin
                                m_yc[i] = Y_MISS; m_st[i] = M_MISS;
                            end else m_yc[i] = m_yc[i] + m_spd[i];
                        end
                    end
                    default: begin
                        m_st[i] = M_WAIT;
                        m_cnt[i] = RANDOM ? (int'(m_lfsr) % 16) + 1 : 1;
                    end
                endcase
                m_btnq[i] = btn[i];
            end
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [LANES-1:0] eh, em, ep;
            logic [10*LANES-1:0] ey;
            for (int i = 0; i < LANES; i++) begin
                eh[i] = (m_st[i] == M_HIT);
                em[i] = (m_st[i] == M_MISS);
                ep[i] = m_pix(i, int'(x), int'(y));
                ey[10*i +: 10] = 10'(m_yc[i]);
            end
            chk("yc_bus", yc_bus, ey);
            chk("hit_pulse", hit_pulse, eh);
            chk("miss_pulse", miss_pulse, em);
            chk("score", score, 64'(m_score));
            chk("combo", combo, 64'(m_combo));
            chk("arrow_pix", arrow_pix, ep);
            chk("any_pix", any_pix, |ep);
        end
    end

    // ---------------- stimulus ----------------
    task automatic pick_xy();
        int r;
        r = $urandom_range(0, LANES - 1);
        x = 10'(LANE_X0 + r * LANE_PITCH + $urandom_range(0, 28) - 14);
        y = 10'(m_yc[r] + $urandom_range(0, 30) - 16);
        if ($urandom_range(0, 7) == 0) y = 10'($urandom_range(0, 1023));
    endtask

    task automatic step(input bit anim, input logic [LANES-1:0] b);
        @(posedge clk);
        #1;
        animate = anim;
        btn = b;
        pick_xy();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, presses, extra;
        bit seen;
        logic [LANES-1:0] bv, prev;
        #2 rst = 1'b1;
        #1 cmp_en = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        x = 10'(LANE_X0); y = 10'(Y_START);
        @(negedge clk);
        chk("rst_yc_bus", yc_bus, {LANES{10'd50}});
        chk("rst_score", score, 0);
        chk("rst_combo", combo, 0);
        chk("rst_pulses", {hit_pulse, miss_pulse}, 0);
        chk("wait_probe_pix", arrow_pix[0], 0);

        // lane 0 spawns on its first animate
        step(1, '0);
        step(0, '0); x = 10'd160; y = 10'd60;
        @(negedge clk);
        chk("spawn_yc0", yc_bus[9:0], 10'd50);
        chk("probe_head_on", arrow_pix[0], 1);
        step(0, '0); x = 10'd172; y = 10'd50;
        @(negedge clk); chk("probe_right_off", arrow_pix[0], 0);
        step(0, '0); x = 10'd154; y = 10'd40;
        @(negedge clk); chk("probe_stem_corner", arrow_pix[0], 1);
        step(0, '0); x = 10'd166; y = 10'd40;
        @(negedge clk); chk("probe_stem_edge", arrow_pix[0], 0);
        step(0, '0); x = 10'd150; y = 10'd50;
        @(negedge clk); chk("probe_head_tip", arrow_pix[0], 1);

        // fall into the window, then press
        n = 0;
        while (!(m_st[0] == M_FALL && m_yc[0] >= HIT_LO) && n < 400) begin step(1, '0); n++; end
        chk("reach_window", n < 400, 1);
        step(0, 4'b0001);
        step(0, 4'b0001); x = 10'd160; y = 10'(m_yc[0]);
        @(negedge clk);
        chk("hit_pulse0", hit_pulse[0], 1);
        chk("hit_pix_drop", arrow_pix[0], 0);
        step(0, 4'b0001);
        @(negedge clk);
        chk("score_after_hit", score, 1);
        step(0, '0);

        // press below the window and hold: must not hit, lane misses
        n = 0;
        while (!(m_st[0] == M_FALL && m_yc[0] >= HIT_LO - 18 && m_yc[0] < HIT_LO - 6) && n < 400) begin
            step(1, '0); n++;
        end
        chk("reach_prewindow", n < 400, 1);
        seen = 0; n = 0;
        while (n < 300) begin
            step(1, 4'b0001);
            @(negedge clk);
            if (hit_pulse[0]) seen = 1;
            if (m_st[0] == M_MISS) break;
            n++;
        end
        chk("held_miss_pulse", miss_pulse[0], 1);
        chk("miss_clamp_yc", yc_bus[9:0], 10'd460);
        chk("held_no_hit", seen, 0);
        step(0, '0);
        @(negedge clk);
        chk("combo_after_miss", combo, 0);
        chk("score_held", score, 1);

        // random traffic
        for (int t = 0; t < 6000; t++) step(1'($urandom_range(0, 1)), LANES'($urandom));

        // async reset between edges
        step(1, '0);
        #3 rst = 1'b1;
        #1;
        chk("arst_yc_bus", yc_bus, {LANES{10'd50}});
        chk("arst_score", score, 0);
        chk("arst_combo", combo, 0);
        chk("arst_pulses", {hit_pulse, miss_pulse}, 0);
        chk("arst_pix", arrow_pix, 0);
        @(posedge clk); #1 rst = 1'b0;

        // always hit: combo climbs to and saturates at 255
        presses = 0; extra = 0; prev = '0; n = 0;
        while (extra < 400 && n < 30000) begin
            for (int i = 0; i < LANES; i++)
                bv[i] = (m_st[i] == M_FALL && m_yc[i] >= HIT_LO && m_yc[i] <= HIT_HI);
            for (int i = 0; i < LANES; i++) if (bv[i] && !prev[i]) presses++;
            prev = bv;
            step(1, bv);
            if (m_combo == 255) extra++;
            n++;
        end
        chk("combo_phase_bound", n < 30000, 1);
        step(0, '0); step(0, '0); step(0, '0);
        @(negedge clk);
        chk("combo_saturated", combo, 255);
        chk("score_total", score, 64'(presses));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/arrow_lanes.md
Name: arrow_lanes

Overview:
Multi-lane successor to the single falling-arrow sprite: LANES independent arrows fall down the screen at fixed x columns. Each lane owns a per-lane FSM, frame-based motion, pseudo-random speed and respawn delay, and edge-detected button hit/miss judgement. A shared score/combo tracker covers all lanes. The block sits between the VGA pixel scanner (x, y, animate) and the colour mux, which consumes arrow_pix/any_pix.

Parameters:
LANES, 4, number of lanes (1..8)
LANE_X0, 160, x centre of lane 0
LANE_PITCH, 100, x spacing between lane centres; lane i centre = LANE_X0 + i*LANE_PITCH
Y_START, 50, spawn y centre
Y_MISS, 460, y at or beyond which a falling arrow is missed
HIT_LO, 400, inclusive lower bound of hit window (yc)
HIT_HI, 440, inclusive upper bound of hit window; HIT_HI < Y_MISS
BASE_SPEED, 3, pixels per animate tick (minimum)
RANDOM, 1, 1: speed = BASE_SPEED + lfsr[1:0], respawn delay = lfsr[3:0]+1; 0: speed = BASE_SPEED, delay = 1
LFSR_SEED, 8'hA5, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
animate  in  1  one-clk frame tick; motion and delay counting occur only on this
x  in  10  current pixel column
y  in  10  current pixel row
btn  in  LANES  per-lane button level, already synchronised
arrow_pix  out  LANES  combinational: pixel (x,y) lies on lane i's glyph
any_pix  out  1  OR of arrow_pix
hit_pulse  out  LANES  registered one-clk pulse per lane hit
miss_pulse  out  LANES  registered one-clk pulse per lane miss
yc_bus  out  10*LANES  lane i centre y at bits [10i+9:10i]
score  out  16  total hits, saturating at 16'hFFFF
combo  out  8  consecutive hits without a miss, saturating at 255

Behaviour:
- Reset (async): lfsr=LFSR_SEED; all lanes in WAIT with delay count 2*i+1; yc=Y_START; btn_q=0; hit_pulse, miss_pulse, score and combo = 0. Reset mid-fall aborts the lane immediately. No pulse is emitted.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every clk.
- Per-lane FSM states: WAIT, FALL, HIT, MISS.
- WAIT: on each animate, count decrements; when count==1 and animate fires: yc<=Y_START, speed latched, state<=FALL.
- FALL: on animate, ny=yc+speed, computed 11-bit with no wrap. If ny>=Y_MISS: yc<=Y_MISS, state<=MISS. Otherwise yc<=ny.
- FALL button: rise = btn[i] & ~btn_q[i]. Rise with HIT_LO<=yc<=HIT_HI: state<=HIT, regardless of animate in the same cycle. Rise outside the window: ignored, no penalty. A held button never re-triggers.
- HIT and MISS: each lasts exactly one clk. The matching pulse is high during that clk. Then state<=WAIT with delay reloaded from RANDOM rule. yc holds.
- Glyph (FALL only; xc = lane centre):
  - stem: xc-6<=x<xc+6 and yc-12<=y<yc+2
  - head: for k=0..9, xc-1-k<=x<xc+1+k and yc+9-k<=y<yc+12-k
  - Unsigned underflow near edges must not create false pixels; use 11-bit signed compare.
- Score/combo update each clk from the pulse vectors:
  - score += popcount(hit_pulse), saturating
  - any miss_pulse: combo<=0 (miss dominates simultaneous hits in other lanes)
  - else combo += popcount(hit_pulse), saturating

Test Plan:
- RANDOM=0, BASE_SPEED=3: assert/release rst, no btn -> lane0 enters FALL after 1 animate. yc=50+3n. Reaches 440 at tick 130; tick 137 clamps yc=460, miss_pulse[0] one clk later, combo=0.
- Same config: btn[0] rises at tick 117 (yc=401) -> hit_pulse[0] next clk. score=1, combo=1, arrow_pix[0] drops, lane respawns at yc=50 after 1 animate.
- btn[0] rises at yc=398 then held through the window -> no hit. Lane misses at 460; score unchanged.
- Lanes 0 and 1 hit in the same clk while lane 2 misses -> score += 2, combo=0.
- Probe pixel (LANE_X0, Y_START+10) with lane0 at yc=50 -> arrow_pix[0]=1. Probe (LANE_X0+12, 50) -> 0. Probe (LANE_X0, 50) during WAIT -> 0.
- Async rst asserted mid-FALL between clk edges -> yc_bus, pulses, score and combo clear immediately. Score saturation: force 255 consecutive hits -> combo stays 255.
